// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared state, ALU, opcode and select encodings for the multicycle CPU
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    JUMP,
    JAL,
    JR,
    HALT
  } state_t;

  localparam logic [3:0] ALU_ADDIU = 4'b0000;
  localparam logic [3:0] ALU_SW    = 4'b0001;
  localparam logic [3:0] ALU_ADDU  = 4'b0010;
  localparam logic [3:0] ALU_JAL   = 4'b0011;
  localparam logic [3:0] ALU_LW    = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_BNE   = 4'b0110;
  localparam logic [3:0] ALU_J     = 4'b0111;
  localparam logic [3:0] ALU_JR    = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_OR   = 6'h25;

  localparam logic       SRC_A_PC     = 1'b0;
  localparam logic       SRC_A_RS     = 1'b1;
  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  // Instruction dispatch out of DECODE; anything unsupported parks the FSM in HALT
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW, OP_SW:     return MEM_ADDR;
      OP_RTYPE:         return (fn == FN_ADDU || fn == FN_OR) ? EXEC_R : (fn == FN_JR) ? JR : HALT;
      OP_ADDIU, OP_LUI: return EXEC_I;
      OP_BNE:           return BRANCH;
      OP_J:             return JUMP;
      OP_JAL:           return JAL;
      default:          return HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// control_decode: per-state datapath control decode for the multicycle controller
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_src,
  output logic       illegal
);

  // Controls per state; opcode/funct stay stable after FETCH so they refine the op within a state
  always_comb begin
    alu_ctrl   = ALU_ADDU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    reg_dst    = DST_RT;
    pc_src     = PC_ALU;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = SRC_B_IMM_SH;
      MEM_ADDR: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = (opcode == OP_SW) ? ALU_SW : ALU_LW;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS;
        alu_ctrl  = (funct == FN_OR) ? ALU_OR : ALU_ADDU;
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = (opcode == OP_LUI) ? ALU_LUI : ALU_ADDIU;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS;
        alu_ctrl  = ALU_BNE;
        pc_src    = PC_ALUOUT;
        pc_write  = ~zero;
      end
      JUMP: begin
        alu_ctrl = ALU_J;
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
      JAL: begin
        alu_ctrl  = ALU_JAL;
        pc_write  = 1'b1;
        pc_src    = PC_JUMP;
        reg_write = 1'b1;
        reg_dst   = DST_RA;
      end
      JR: begin
        alu_ctrl  = ALU_JR;
        alu_src_a = SRC_A_RS;
        pc_write  = 1'b1;
        pc_src    = PC_RS;
      end
      HALT: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: state register and next-state logic of the multicycle CPU controller
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  state_t st, nxt;
  logic d_mem_read, d_mem_write, d_ir_write, d_reg_write, d_pc_write;

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= FETCH;
    else st <= nxt;
  end

  // Next state: memory states stall on mem_ready, HALT absorbs until reset
  always_comb begin
    nxt = st;
    case (st)
      FETCH:            nxt = mem_ready ? DECODE : FETCH;
      DECODE:           nxt = dispatch(opcode, funct);
      MEM_ADDR:         nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:           nxt = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:           nxt = mem_ready ? FETCH : MEM_WR;
      EXEC_R, EXEC_I:   nxt = ALU_WB;
      HALT:             nxt = HALT;
      default:          nxt = FETCH;
    endcase
  end

  control_decode u_decode (
    .state      (st),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .mem_read   (d_mem_read),
    .mem_write  (d_mem_write),
    .ir_write   (d_ir_write),
    .reg_write  (d_reg_write),
    .mem_to_reg (mem_to_reg),
    .pc_write   (d_pc_write),
    .reg_dst    (reg_dst),
    .pc_src     (pc_src),
    .illegal    (illegal)
  );

  // Reset state is FETCH, which reads memory, so enables are masked while rst_n is low
  assign mem_read  = rst_n & d_mem_read;
  assign mem_write = rst_n & d_mem_write;
  assign ir_write  = rst_n & d_ir_write;
  assign reg_write = rst_n & d_reg_write;
  assign pc_write  = rst_n & d_pc_write;
  assign state     = st;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multicycle controller
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int D = -1;

  typedef struct {
    string       tag;
    logic [22:0] v;
    logic [22:0] m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [3:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg, pc_write;
  logic [1:0] reg_dst, pc_src;
  logic       illegal;
  logic [3:0] state;
  logic [22:0] obs;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .pc_write   (pc_write),
    .reg_dst    (reg_dst),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .state      (state)
  );

  assign obs = {state, alu_ctrl, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                reg_write, mem_to_reg, pc_write, reg_dst, pc_src, illegal};

  // Fields passed as D are don't-care for that state
  function automatic exp_t ex(string tag, int st, int alu, int sa, int sbv, int io, bit mr, bit mw,
                              bit irw, bit rw, int m2r, bit pcw, int rd, int ps, bit ill);
    exp_t e;
    e.tag = tag;
    e.v = {4'(st), 4'(alu), 1'(sa), 2'(sbv), 1'(io), mr, mw, irw, rw, 1'(m2r), pcw, 2'(rd), 2'(ps), ill};
    e.m = {4'hF, {4{alu != D}}, sa != D, {2{sbv != D}}, io != D, 4'hF, m2r != D, 1'b1,
           {2{rd != D}}, {2{ps != D}}, 1'b1};
    return e;
  endfunction

  task automatic p_rst();   q.push_back(ex("reset", FETCH, D, D, D, D, 0, 0, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_fetch(bit r); q.push_back(ex("fetch", FETCH, 'b0010, 0, 1, 0, 1, 0, r, 0, D, r, D, 0, 0)); endtask
  task automatic p_decode(); q.push_back(ex("decode", DECODE, 'b0010, 0, 3, D, 0, 0, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_maddr(int a); q.push_back(ex("mem_addr", MEM_ADDR, a, 1, 2, D, 0, 0, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_mrd();   q.push_back(ex("mem_rd", MEM_RD, D, D, D, 1, 1, 0, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_mwb();   q.push_back(ex("mem_wb", MEM_WB, D, D, D, D, 0, 0, 0, 1, 1, 0, 0, D, 0)); endtask
  task automatic p_mwr();   q.push_back(ex("mem_wr", MEM_WR, D, D, D, 1, 0, 1, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_exr(int a); q.push_back(ex("exec_r", EXEC_R, a, 1, 0, D, 0, 0, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_exi(int a); q.push_back(ex("exec_i", EXEC_I, a, 1, 2, D, 0, 0, 0, 0, D, 0, D, D, 0)); endtask
  task automatic p_awb(int rd); q.push_back(ex("alu_wb", ALU_WB, D, D, D, D, 0, 0, 0, 1, 0, 0, rd, D, 0)); endtask
  task automatic p_br(bit z); q.push_back(ex("branch", BRANCH, 'b0110, 1, 0, D, 0, 0, 0, 0, D, !z, D, 1, 0)); endtask
  task automatic p_j();     q.push_back(ex("jump", JUMP, 'b0111, D, D, D, 0, 0, 0, 0, D, 1, D, 2, 0)); endtask
  task automatic p_jal();   q.push_back(ex("jal", JAL, 'b0011, D, D, D, 0, 0, 0, 1, D, 1, 2, 2, 0)); endtask
  task automatic p_jr();    q.push_back(ex("jr", JR, 'b1000, D, D, D, 0, 0, 0, 0, D, 1, D, 3, 0)); endtask
  task automatic p_halt();  q.push_back(ex("halt", HALT, D, D, D, D, 0, 0, 0, 0, D, 0, D, D, 1)); endtask

  // Each cycle: sample on the falling edge against the next scoreboard entry, then step past the rising edge
  task automatic run(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL scoreboard_empty observed=%0d expected=>0", q.size());
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        assert ((obs & e.m) === (e.v & e.m)) else begin
          fails++;
          $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.m, e.v & e.m);
        end
      end
      tests++;
      assert (!(mem_read && mem_write)) else begin
        fails++;
        $error("FAIL rd_wr_exclusive observed=%b%b expected=not_both", mem_read, mem_write);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [3:0] o, logic [3:0] x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    p_rst(); p_rst(); run(2);
    rst_n = 1'b1; opcode = 6'h23;
    p_fetch(1); p_decode(); p_maddr('b0100); p_mrd(); p_mwb(); run(5);
    opcode = 6'h2B;
    p_fetch(1); p_decode(); p_maddr('b0001); run(3);
    mem_ready = 1'b0; p_mwr(); p_mwr(); p_mwr(); run(3);
    mem_ready = 1'b1; p_mwr(); run(1);
    mem_ready = 1'b0; opcode = 6'h00; funct = 6'h21; p_fetch(0); p_fetch(0); run(2);
    mem_ready = 1'b1; p_fetch(1); p_decode(); p_exr('b0010); p_awb(1); run(4);
    funct = 6'h25; p_fetch(1); p_decode(); p_exr('b0101); p_awb(1); run(4);
    opcode = 6'h09; p_fetch(1); p_decode(); p_exi('b0000); p_awb(0); run(4);
    opcode = 6'h0F; p_fetch(1); p_decode(); p_exi('b1001); p_awb(0); run(4);
    opcode = 6'h05; zero = 1'b1; p_fetch(1); p_decode(); p_br(1); run(3);
    zero = 1'b0; p_fetch(1); p_decode(); p_br(0); run(3);
    opcode = 6'h02; p_fetch(1); p_decode(); p_j(); run(3);
    opcode = 6'h03; p_fetch(1); p_decode(); p_jal(); run(3);
    opcode = 6'h00; funct = 6'h08; p_fetch(1); p_decode(); p_jr(); run(3);
    opcode = 6'h23; p_fetch(1); p_decode(); p_maddr('b0100); run(3);
    mem_ready = 1'b0; p_mrd(); p_mrd(); run(2);
    #2;
    chk("stall_mem_read", {3'b0, mem_read}, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_read_async", {3'b0, mem_read}, 4'h0);
    chk("rst_state_async", state, FETCH);
    @(posedge clk);
    #1;
    p_rst(); run(1);
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'h09;
    p_fetch(1); p_decode(); p_exi('b0000); p_awb(0); run(4);
    opcode = 6'h3F; p_fetch(1); p_decode();
    for (int i = 0; i < 10; i++) p_halt();
    run(12);
    #2;
    chk("halt_illegal", {3'b0, illegal}, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_illegal_async", {3'b0, illegal}, 4'h0);
    chk("rst_state_from_halt", state, FETCH);
    p_rst(); run(1);
    rst_n = 1'b1; opcode = 6'h00; funct = 6'h20;
    p_fetch(1); p_decode(); p_halt(); p_halt(); run(4);
    chk("scoreboard_drained", 4'(q.size()), 4'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
